// File: rtl/mod_voice_scheduler.sv
// Voice scheduler: shares one sine source across NUM_VOICES voices, walking them once
// per sample tick and mixing the attenuated results into one saturated signed sample.
module mod_voice_scheduler #(
  parameter int unsigned NUM_VOICES   = 4,
  parameter int unsigned SINE_LATENCY = 1,
  parameter int unsigned MIX_SHIFT    = 2,
  localparam int unsigned IDX_W       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sample_tick,
  input  logic [NUM_VOICES-1:0] i_voice_en,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_voice,
  input  logic [31:0]           i_wr_period,
  output logic [63:0]           o_src_time,
  output logic [31:0]           o_src_period,
  input  logic [31:0]           i_src_sine,
  output logic [31:0]           o_mix,
  output logic                  o_mix_valid,
  output logic                  o_busy,
  output logic                  o_overrun
);

  localparam int unsigned ACC_W  = 32 + $clog2(NUM_VOICES) + 1;
  localparam int unsigned WCNT_W = (SINE_LATENCY > 1) ? $clog2(SINE_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StWait, StDone} state_t;

  state_t                    r_state, w_state_d;
  logic [IDX_W-1:0]          r_idx, w_idx_d;
  logic signed [ACC_W-1:0]   r_acc, w_acc_d;
  logic [WCNT_W-1:0]         r_wcnt, w_wcnt_d;
  logic [31:0]               r_period [NUM_VOICES];
  logic [63:0]               r_time   [NUM_VOICES];
  logic [63:0]               r_src_time;
  logic [31:0]               r_src_period;
  logic [31:0]               r_mix;
  logic                      r_mix_valid;
  logic                      r_overrun;

  logic                      w_last;
  logic                      w_voice_on;
  logic                      w_drive;
  logic                      w_adv;
  logic signed [31:0]        w_sine_sh;
  logic signed [ACC_W-1:0]   w_sine_ext;
  logic [63:0]               w_time_inc;
  logic [63:0]               w_time_nxt;
  logic [ACC_W-32:0]         w_acc_hi;
  logic [31:0]               w_mix_sat;

  assign w_last     = (r_idx == IDX_W'(NUM_VOICES - 1));
  assign w_voice_on = i_voice_en[r_idx] && (r_period[r_idx] != 32'd0);
  assign w_sine_sh  = $signed(i_src_sine) >>> MIX_SHIFT;
  assign w_sine_ext = {{(ACC_W-32){w_sine_sh[31]}}, w_sine_sh};
  assign w_time_inc = r_time[r_idx] + 64'd1;
  assign w_time_nxt = (w_time_inc == {32'd0, r_period[r_idx]}) ? 64'd0 : w_time_inc;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_acc_d   = r_acc;
    w_wcnt_d  = r_wcnt;
    w_drive   = 1'b0;
    w_adv     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_sample_tick) begin
          w_idx_d   = '0;
          w_acc_d   = '0;
          w_state_d = StScan;
        end
      end
      StScan: begin
        if (w_voice_on) begin
          w_drive   = 1'b1;
          w_wcnt_d  = WCNT_W'(SINE_LATENCY - 1);
          w_state_d = StWait;
        end else if (w_last) begin
          w_state_d = StDone;
        end else begin
          w_idx_d = r_idx + IDX_W'(1);
        end
      end
      StWait: begin
        if (r_wcnt == '0) begin
          w_acc_d = r_acc + w_sine_ext;
          w_adv   = 1'b1;
          if (w_last) begin
            w_state_d = StDone;
          end else begin
            w_idx_d   = r_idx + IDX_W'(1);
            w_state_d = StScan;
          end
        end else begin
          w_wcnt_d = r_wcnt - WCNT_W'(1);
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Saturate the accumulator being entered into DONE so o_mix is valid alongside the pulse.
  assign w_acc_hi  = w_acc_d[ACC_W-1:31];
  assign w_mix_sat = ((&w_acc_hi) || !(|w_acc_hi)) ? w_acc_d[31:0] :
                     (w_acc_d[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_acc        <= '0;
      r_wcnt       <= '0;
      r_src_time   <= '0;
      r_src_period <= '0;
      r_mix        <= '0;
      r_mix_valid  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx_d;
      r_acc       <= w_acc_d;
      r_wcnt      <= w_wcnt_d;
      r_mix_valid <= (w_state_d == StDone);
      if (w_state_d == StDone) begin
        r_mix <= w_mix_sat;
      end
      if (w_drive) begin
        r_src_time   <= r_time[r_idx];
        r_src_period <= r_period[r_idx];
      end
      if (i_sample_tick && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // A period write wins over the same-cycle time advance of that voice.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        r_period[k] <= '0;
        r_time[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        if (i_wr_en && (32'(i_wr_voice) == k)) begin
          r_period[k] <= i_wr_period;
          r_time[k]   <= '0;
        end else if (w_adv && (32'(r_idx) == k)) begin
          r_time[k] <= w_time_nxt;
        end
      end
    end
  end

  assign o_src_time   = r_src_time;
  assign o_src_period = r_src_period;
  assign o_mix        = r_mix;
  assign o_mix_valid  = r_mix_valid;
  assign o_busy       = (r_state != StIdle);
  assign o_overrun    = r_overrun;

endmodule

// File: doc/mod_voice_scheduler.md
Name: mod_voice_scheduler

Overview:
- Time-multiplexes one shared sine source (time/period in, signed 32-bit sine out) across NUM_VOICES voices.
- Keeps a per-voice period register and a per-voice time counter.
- On each audio sample tick it walks the voices in order, drives the source, and accumulates the attenuated results.
- Emits one mixed signed sample per tick with a one-cycle valid pulse.

Parameters:
- NUM_VOICES, 4, number of voices; at least 1.
- SINE_LATENCY, 1, cycles from the registered source inputs changing to i_src_sine being valid; at least 1.
- MIX_SHIFT, 2, arithmetic right shift applied to each voice sample before accumulation.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_sample_tick  in  1  one-cycle pulse per audio sample
- i_voice_en  in  NUM_VOICES  per-voice enable; bit k is voice k
- i_wr_en  in  1  period write strobe
- i_wr_voice  in  $clog2(NUM_VOICES) (min 1)  voice index for the write
- i_wr_period  in  32  new period value, unsigned
- o_src_time  out  64  time input driven to the shared sine source
- o_src_period  out  32  period input driven to the shared sine source
- i_src_sine  in  32  signed sine result from the source
- o_mix  out  32  signed mixed sample
- o_mix_valid  out  1  one-cycle pulse; o_mix is valid on this cycle
- o_busy  out  1  high while a frame is in progress (any state except IDLE)
- o_overrun  out  1  sticky flag: a tick arrived while busy

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - All period and time registers, accumulator, index, o_src_time, o_src_period and o_mix go to 0.
  - o_mix_valid, o_busy and o_overrun go to 0.
  - FSM goes to IDLE.
  - Reset mid-frame abandons the frame; no valid pulse is produced.
- State machine: IDLE, SCAN, WAIT, DONE.
- IDLE:
  - On i_sample_tick: idx=0, acc=0, go to SCAN.
- SCAN (one cycle per voice):
  - If i_voice_en[idx]=1 and period[idx]!=0: register o_src_time=time[idx] and o_src_period=period[idx], load the wait counter, go to WAIT.
  - Otherwise skip the voice: time is not advanced and the source is not driven. Go to DONE if idx=NUM_VOICES-1, else idx+1 and stay in SCAN.
  - i_voice_en is sampled only in the voice's SCAN cycle.
- WAIT (exactly SINE_LATENCY cycles):
  - On the last WAIT cycle: acc += (i_src_sine >>> MIX_SHIFT), sign-extended.
  - Same cycle: time[idx] = (time[idx]+1 == period[idx]) ? 0 : time[idx]+1.
  - Then go to DONE if idx is last, else idx+1 and SCAN.
- DONE (one cycle):
  - o_mix = acc saturated to signed 32-bit (clamp to 0x7FFFFFFF / 0x80000000).
  - o_mix_valid=1. Go to IDLE.
- Accumulator width: 32 + $clog2(NUM_VOICES) + 1, signed.
- Latency: a tick sampled in cycle 0 puts SCAN in cycle 1. Each enabled voice costs 1+SINE_LATENCY cycles, each skipped voice 1 cycle. DONE follows the last voice.
  - All voices enabled, defaults: o_mix_valid in cycle 9.
  - All voices disabled: o_mix_valid in cycle 5 with o_mix=0.
- o_mix holds its value until the next DONE. o_src_time and o_src_period hold their last values between frames.
- A tick while o_busy=1 (including the DONE cycle) is ignored and sets o_overrun. Only reset clears o_overrun.
- Period writes are accepted in any state:
  - period[i_wr_voice] = i_wr_period and time[i_wr_voice] = 0, applied in the next cycle.
  - An already-registered o_src_period is unaffected.
  - A write in the same cycle as that voice's time update takes priority; time ends at 0.
  - A write with i_wr_period=0 disables the voice.
  - i_wr_voice >= NUM_VOICES is ignored.

Test Plan:
- Reset with all inputs toggling -> o_mix=0, o_mix_valid=0, o_busy=0, o_overrun=0, o_src_time=0, o_src_period=0.
- Write voice0 period=4; enable voice0 only; bench source returns 1000; five ticks spaced 20 cycles apart:
  - o_src_time sequence 0,1,2,3,0 with o_src_period=4.
  - o_mix=250 each frame; o_mix_valid in cycle 6 after each tick.
- All four voices enabled with period 10; MIX_SHIFT=0:
  - Source returns 0x40000000 -> o_mix=0x7FFFFFFF (saturated).
  - Source returns 0x80000000 -> o_mix=0x80000000.
- Voice2 enabled with period 0 -> never driven and its time stays 0; frame length is 1 cycle shorter for that voice than for an enabled voice.
- Tick, then a second tick 3 cycles later -> exactly one o_mix_valid, o_overrun=1; the next legal tick produces a correct frame.
- Period write to voice1 during its WAIT cycle -> time[1]=0, and the frame still uses the old period. Assert i_rst_n low mid-WAIT -> all outputs 0 immediately and no valid pulse.
